// File: rtl/riscv_mem_pkg.sv
// Shared types for the data memory responder.
// Word width, FSM states and fault causes.
package riscv_mem_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_RANGE
  } err_t;

  function automatic err_t err_cause(
    input logic [WORD_W-1:0] addr,
    input int unsigned       depth
  );
    err_t c;
    c = ERR_NONE;
    if (addr[1:0] != 2'b00)
      c = ERR_MISALIGN;
    else if (32'(addr[WORD_W-1:2]) >= depth)
      c = ERR_RANGE;
    return c;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one byte-enabled synchronous write port,
// one combinational read port, contents survive reset.
module mem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i])
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: one request in flight,
// fault check on alignment and range, held response.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept;
  logic              commit;

  logic              cap_we;
  logic [WORD_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [STRB_W-1:0] cap_wstrb;

  logic              op_we;
  logic [WORD_W-1:0] op_addr;
  logic [WORD_W-1:0] op_wdata;
  logic [STRB_W-1:0] op_wstrb;
  logic              op_err;
  logic [AW-1:0]     op_idx;
  logic [WORD_W-1:0] mem_rdata;

  assign req_ready = reset && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY = 1 the commit edge is the accept edge,
  // so operands come straight from the request port.
  always_comb begin
    op_we    = cap_we;
    op_addr  = cap_addr;
    op_wdata = cap_wdata;
    op_wstrb = cap_wstrb;
    if (state == IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_wstrb = req_wstrb;
    end
  end

  assign op_err = (err_cause(op_addr, DEPTH) != ERR_NONE);
  assign op_idx = op_addr[AW+1:2];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx = CNT_INIT;
          if (LATENCY == 1) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_wstrb <= req_wstrb;
      end
      if (commit) begin
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_we) ? '0 : mem_rdata;
      end
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (commit && op_we && !op_err),
    .waddr (op_idx),
    .wdata (op_wdata),
    .wstrb (op_wstrb),
    .raddr (op_idx),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed vector bench for data_mem_responder.
// Table of request/response records plus multi-cycle sequences.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  data_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [31:0] addr,
                              logic [31:0] wdata, logic [3:0] wstrb,
                              logic [31:0] rdata, logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.wstrb = wstrb; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: accept, latency count, response, handshake.
  task automatic do_req(string tag, vec_t v);
    int lat;
    @(negedge clock);
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wstrb = v.wstrb;
    req_valid = 1'b1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b1;
    req_addr  = 32'h0000_0010;
    req_wdata = 32'h0BAD_0BAD;
    req_wstrb = 4'hF;
    chk({tag, ".busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    while (lat < 20) begin
      if (rsp_valid) break;
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(LAT));
    chk({tag, ".rdata"}, rsp_rdata, v.rdata);
    chk({tag, ".err"}, 32'(rsp_err), 32'(v.err));
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    chk({tag, ".done"}, 32'({rsp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    rsp_ready = 1'b0;

    repeat (4) begin
      @(negedge clock);
      chk("rst.out", {req_ready, rsp_valid, rsp_err, 29'd0} | rsp_rdata, 32'd0);
    end
    #10 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.valid", 32'(rsp_valid), 32'd0);

    tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 0));
    tbl.push_back(mk(0, 32'h11, 32'h0,        4'h0, 32'h0, 1));
    tbl.push_back(mk(0, 32'h100, 32'h0,       4'h0, 32'h0, 1));
    tbl.push_back(mk(1, 32'h11, 32'h11111111, 4'hF, 32'h0, 1));
    tbl.push_back(mk(1, 32'h100, 32'h22222222, 4'hF, 32'h0, 1));
    tbl.push_back(mk(0, 32'hFFFFFFFC, 32'h0,  4'h0, 32'h0, 1));
    tbl.push_back(mk(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 0));
    tbl.push_back(mk(1, 32'hFC, 32'hCAFEF00D, 4'hF, 32'h0, 0));
    tbl.push_back(mk(0, 32'hFC, 32'h0,        4'h0, 32'hCAFEF00D, 0));
    tbl.push_back(mk(1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 0));
    tbl.push_back(mk(1, 32'h14, 32'h00000000, 4'hF, 32'h0, 0));
    tbl.push_back(mk(1, 32'h14, 32'h12345678, 4'hA, 32'h0, 0));
    tbl.push_back(mk(0, 32'h14, 32'h0,        4'h0, 32'h12005600, 0));
    tbl.push_back(mk(1, 32'h20, 32'h5A5A5A5A, 4'hF, 32'h0, 0));
    tbl.push_back(mk(0, 32'h20, 32'h0,        4'h0, 32'h5A5A5A5A, 0));

    foreach (tbl[i])
      do_req($sformatf("v%0d", i), tbl[i]);

    // Backpressure: response held while rsp_ready stays low.
    @(negedge clock);
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_we    = 1'b1;
    req_addr  = 32'h14;
    req_wdata = 32'h99999999;
    req_wstrb = 4'hF;
    repeat (LAT) @(posedge clock);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d.valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d.rdata", c), rsp_rdata, 32'hDEADBEAA);
      chk($sformatf("bp%0d.err", c), 32'(rsp_err), 32'd0);
      chk($sformatf("bp%0d.ready", c), 32'(req_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    chk("bp.done", 32'({rsp_valid, req_ready}), 32'b01);
    do_req("bp.chk14", mk(0, 32'h14, 32'h0, 4'h0, 32'h12005600, 0));

    // Reset while a store sits in WAIT.
    @(negedge clock);
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h0BADF00D;
    req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("wr.rst.valid", 32'(rsp_valid), 32'd0);
    chk("wr.rst.ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("wr.norsp%0d", c), 32'(rsp_valid), 32'd0);
    end
    do_req("wr.old20", mk(0, 32'h20, 32'h0, 4'h0, 32'h5A5A5A5A, 0));
    do_req("wr.keep10", mk(0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
